// File: rtl/add_x1.sv
// Full adder with a combinational single-bit path and a bit-serial WIDTH-bit adder
// that accepts operand bits LSB first and assembles the sum, carry-out and overflow.
module add_x1 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             sum,
    output logic             carry,
    input  logic             ser_start,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] ser_sum,
    output logic             ser_cout,
    output logic             ser_ovf,
    output logic             ser_busy,
    output logic             ser_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    logic          cq;
    logic [CW-1:0] cnt;
    logic          bit_s;
    logic          cout_s;

    assign sum    = A ^ B ^ C;
    assign carry  = maj(A, B, C);

    assign bit_s  = A ^ B ^ cq;
    assign cout_s = maj(A, B, cq);

    always_ff @(posedge clk) begin
        if (rst) begin
            cq       <= 1'b0;
            cnt      <= '0;
            ser_sum  <= '0;
            ser_cout <= 1'b0;
            ser_ovf  <= 1'b0;
            ser_busy <= 1'b0;
            ser_done <= 1'b0;
        end else if (ser_start) begin
            cq       <= C;
            cnt      <= '0;
            ser_sum  <= '0;
            ser_cout <= 1'b0;
            ser_ovf  <= 1'b0;
            ser_busy <= 1'b1;
            ser_done <= 1'b0;
        end else if (ser_busy && ser_valid) begin
            // New bit enters at the MSB so the LSB-first stream ends up right-aligned
            ser_sum <= {bit_s, ser_sum[WIDTH-1:1]};
            cq      <= cout_s;
            cnt     <= cnt + CW'(1);
            if (cnt == LAST) begin
                ser_busy <= 1'b0;
                ser_done <= 1'b1;
                ser_cout <= cout_s;
                // cq still holds the carry into the MSB at this edge
                ser_ovf  <= cq ^ cout_s;
            end
        end
    end

endmodule

// File: tb/tb_add_x1.sv
// Bench for add_x1: table-driven full-adder and serial vectors, hand-written
// reset/restart sequences, and randomized serial additions against an arithmetic model.
module tb_add_x1;

    logic        clk = 1'b0;
    logic        rst;
    logic        A, B, C;
    logic        s4_start, s4_valid, s64_start, s64_valid;
    logic        sum4, carry4, sum64, carry64;
    logic [3:0]  s4_sum;
    logic [63:0] s64_sum;
    logic        s4_cout, s4_ovf, s4_busy, s4_done;
    logic        s64_cout, s64_ovf, s64_busy, s64_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    add_x1 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .sum(sum4), .carry(carry4),
        .ser_start(s4_start), .ser_valid(s4_valid), .ser_sum(s4_sum),
        .ser_cout(s4_cout), .ser_ovf(s4_ovf), .ser_busy(s4_busy), .ser_done(s4_done)
    );

    add_x1 #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .sum(sum64), .carry(carry64),
        .ser_start(s64_start), .ser_valid(s64_valid), .ser_sum(s64_sum),
        .ser_cout(s64_cout), .ser_ovf(s64_ovf), .ser_busy(s64_busy), .ser_done(s64_done)
    );

    typedef struct {
        logic [2:0] abc;
        logic       s;
        logic       c;
    } comb_vec_t;

    typedef struct {
        int          w;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } ser_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] g_sum(input int w);
        return (w == 4) ? {60'd0, s4_sum} : s64_sum;
    endfunction
    function automatic logic g_cout(input int w);
        return (w == 4) ? s4_cout : s64_cout;
    endfunction
    function automatic logic g_ovf(input int w);
        return (w == 4) ? s4_ovf : s64_ovf;
    endfunction
    function automatic logic g_busy(input int w);
        return (w == 4) ? s4_busy : s64_busy;
    endfunction
    function automatic logic g_done(input int w);
        return (w == 4) ? s4_done : s64_done;
    endfunction

    task automatic set_ctl(input int w, input logic st, input logic vl);
        if (w == 4) begin
            s4_start = st;
            s4_valid = vl;
        end else begin
            s64_start = st;
            s64_valid = vl;
        end
    endtask

    // Reference: plain integer arithmetic on the w-bit operands
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, output logic [63:0] s, output logic co,
                         output logic ov);
        logic [65:0]        mask, ua, ub, full;
        logic signed [65:0] sa, sb, ss, smax, smin;
        mask = (66'd1 << w) - 66'd1;
        ua   = {2'b00, a} & mask;
        ub   = {2'b00, b} & mask;
        full = ua + ub + 66'(cin);
        s    = 64'(full & mask);
        co   = full[w];
        sa   = a[w-1] ? $signed(ua - (66'd1 << w)) : $signed(ua);
        sb   = b[w-1] ? $signed(ub - (66'd1 << w)) : $signed(ub);
        ss   = sa + sb + $signed(66'(cin));
        smax = $signed((66'd1 << (w - 1)) - 66'd1);
        smin = -$signed(66'd1 << (w - 1));
        ov   = (ss > smax) || (ss < smin);
    endtask

    task automatic do_start(input int w, input logic cin);
        set_ctl(w, 1'b1, 1'b0);
        C = cin;
        @(negedge clk);
        set_ctl(w, 1'b0, 1'b0);
    endtask

    task automatic feed(input int w, input logic [63:0] a, input logic [63:0] b,
                        input int nbits, input int maxgap, input string tag);
        for (int i = 0; i < nbits; i++) begin
            A = a[i];
            B = b[i];
            set_ctl(w, 1'b0, 1'b1);
            @(negedge clk);
            set_ctl(w, 1'b0, 1'b0);
            if (i < nbits - 1) begin
                int g;
                g = $urandom_range(maxgap, 0);
                for (int k = 0; k < g; k++) begin
                    A = 1'($urandom);
                    B = 1'($urandom);
                    @(negedge clk);
                end
                if (g > 0 && w == 4) chk({tag, " busy in gap"}, 64'(g_busy(w)), 64'd1);
            end
        end
    endtask

    task automatic chk_result(input int w, input logic [63:0] es, input logic eco,
                              input logic eov, input string tag);
        chk({tag, " sum"},  g_sum(w),         es);
        chk({tag, " cout"}, 64'(g_cout(w)),   64'(eco));
        chk({tag, " ovf"},  64'(g_ovf(w)),    64'(eov));
        chk({tag, " done"}, 64'(g_done(w)),   64'd1);
        chk({tag, " busy"}, 64'(g_busy(w)),   64'd0);
    endtask

    task automatic run_ser(input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input int maxgap, input logic [63:0] es,
                           input logic eco, input logic eov, input string tag);
        do_start(w, cin);
        chk({tag, " start busy"}, 64'(g_busy(w)), 64'd1);
        chk({tag, " start done"}, 64'(g_done(w)), 64'd0);
        feed(w, a, b, w, maxgap, tag);
        chk_result(w, es, eco, eov, tag);
    endtask

    comb_vec_t   ctab[8];
    ser_vec_t    stab[7];
    logic [63:0] ms, hs;
    logic        mco, mov;

    initial begin
        // {A,B,C} = 0..7
        ctab[0] = '{3'd0, 1'b0, 1'b0};
        ctab[1] = '{3'd1, 1'b1, 1'b0};
        ctab[2] = '{3'd2, 1'b1, 1'b0};
        ctab[3] = '{3'd3, 1'b0, 1'b1};
        ctab[4] = '{3'd4, 1'b1, 1'b0};
        ctab[5] = '{3'd5, 1'b0, 1'b1};
        ctab[6] = '{3'd6, 1'b0, 1'b1};
        ctab[7] = '{3'd7, 1'b1, 1'b1};

        stab[0] = '{4,  64'h7, 64'h1, 1'b0, 64'h8, 1'b0, 1'b1};
        stab[1] = '{4,  64'hF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        stab[2] = '{4,  64'h8, 64'h8, 1'b0, 64'h0, 1'b1, 1'b1};
        stab[3] = '{4,  64'h5, 64'h2, 1'b1, 64'h8, 1'b0, 1'b1};
        stab[4] = '{4,  64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0};
        stab[5] = '{64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        stab[6] = '{64, 64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};

        rst = 1'b1;
        A = 1'b0; B = 1'b0; C = 1'b0;
        s4_start = 1'b0; s4_valid = 1'b0; s64_start = 1'b0; s64_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int w = 4; w <= 64; w += 60) begin
            chk("reset sum",  g_sum(w),        64'd0);
            chk("reset cout", 64'(g_cout(w)),  64'd0);
            chk("reset ovf",  64'(g_ovf(w)),   64'd0);
            chk("reset busy", 64'(g_busy(w)),  64'd0);
            chk("reset done", 64'(g_done(w)),  64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            {A, B, C} = ctab[i].abc;
            #1;
            chk($sformatf("comb sum abc=%0d", i),    64'(sum4),    64'(ctab[i].s));
            chk($sformatf("comb carry abc=%0d", i),  64'(carry4),  64'(ctab[i].c));
            chk($sformatf("comb sum64 abc=%0d", i),  64'(sum64),   64'(ctab[i].s));
            chk($sformatf("comb carry64 abc=%0d", i), 64'(carry64), 64'(ctab[i].c));
        end
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_ser(stab[i].w, stab[i].a, stab[i].b, stab[i].cin, 0,
                    stab[i].s, stab[i].co, stab[i].ov, $sformatf("tab%0d", i));
            if (stab[i].w == 4)
                run_ser(4, stab[i].a, stab[i].b, stab[i].cin, 3,
                        stab[i].s, stab[i].co, stab[i].ov, $sformatf("tab%0d gap", i));
        end

        // Result holds while stray valid bits arrive with no operation active
        hs = g_sum(4);
        for (int k = 0; k < 3; k++) begin
            A = 1'($urandom); B = 1'($urandom);
            set_ctl(4, 1'b0, 1'b1);
            @(negedge clk);
        end
        set_ctl(4, 1'b0, 1'b0);
        chk_result(4, hs, 1'b0, 1'b0, "hold");

        // Reset in the middle of an operation
        do_start(4, 1'b0);
        feed(4, 64'hF, 64'h0, 2, 0, "rstmid");
        chk("rstmid partial", g_sum(4), 64'hC);
        rst = 1'b1;
        A = 1'b1; B = 1'b0; C = 1'b1;
        #1;
        chk("comb under rst sum",   64'(sum4),   64'd0);
        chk("comb under rst carry", 64'(carry4), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid sum",  g_sum(4),        64'd0);
        chk("rstmid cout", 64'(g_cout(4)),  64'd0);
        chk("rstmid ovf",  64'(g_ovf(4)),   64'd0);
        chk("rstmid busy", 64'(g_busy(4)),  64'd0);
        chk("rstmid done", 64'(g_done(4)),  64'd0);
        chk("rstmid done64", 64'(g_done(64)), 64'd0);
        feed(4, 64'hF, 64'hF, 4, 0, "postrst");
        chk("postrst sum",  g_sum(4),        64'd0);
        chk("postrst busy", 64'(g_busy(4)),  64'd0);
        chk("postrst done", 64'(g_done(4)),  64'd0);

        // Restart with start and valid in the same cycle
        do_start(4, 1'b1);
        feed(4, 64'h3, 64'h3, 2, 0, "restart");
        A = 1'b1; B = 1'b1; C = 1'b0;
        set_ctl(4, 1'b1, 1'b1);
        @(negedge clk);
        set_ctl(4, 1'b0, 1'b0);
        chk("restart cleared sum", g_sum(4),       64'd0);
        chk("restart busy",        64'(g_busy(4)), 64'd1);
        feed(4, 64'h6, 64'h5, 4, 0, "restart");
        chk_result(4, 64'hB, 1'b0, 1'b1, "restart");

        for (int i = 0; i < 24; i++) begin
            logic [63:0] a, b;
            logic        cin;
            a   = {60'd0, 4'($urandom)};
            b   = {60'd0, 4'($urandom)};
            cin = 1'($urandom);
            model(4, a, b, cin, ms, mco, mov);
            run_ser(4, a, b, cin, 3, ms, mco, mov, $sformatf("rnd4 #%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            logic [63:0] a, b;
            logic        cin;
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom);
            model(64, a, b, cin, ms, mco, mov);
            run_ser(64, a, b, cin, 1, ms, mco, mov, $sformatf("rnd64 #%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
